// File: rtl/mont_pkg.sv
// Shared types and defaults for the Montgomery exponentiation controller.
package mont_pkg;

  localparam int N_WIDTH_DEF = 1024;
  localparam int E_WIDTH_DEF = 1024;

  // Operand B of the final multiply; leaving Montgomery form is a multiply by one.
  localparam logic MONT_ONE = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_SQR_REQ  = 4'd2,
    S_SQR_WAIT = 4'd3,
    S_MUL_REQ  = 4'd4,
    S_MUL_WAIT = 4'd5,
    S_OUT_REQ  = 4'd6,
    S_OUT_WAIT = 4'd7,
    S_DONE     = 4'd8
  } state_t;

endpackage

// File: rtl/mont_lz_scan.sv
// Chunked leading-one finder for the exponent, one 64-bit chunk per cycle from the top.
// Only built when MONT_EXP_SKIP_LZ_EN is defined.
`ifdef MONT_EXP_SKIP_LZ_EN
module mont_lz_scan #(
  parameter int E_WIDTH = 1024,
  parameter int IW      = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               scan_i,
  input  logic [E_WIDTH-1:0] e_i,
  output logic               found_o,
  output logic               zero_o,
  output logic [IW-1:0]      idx_o
);
  localparam int CW  = (E_WIDTH < 64) ? E_WIDTH : 64;
  localparam int NCH = (E_WIDTH + CW - 1) / CW;
  localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*CW-1:0] e_pad;
  logic [CW-1:0]     chunk;
  logic [CIW-1:0]    ch_q, ch_d;
  logic              hit;
  int                pos;

  assign e_pad = (NCH*CW)'(e_i);
  assign chunk = e_pad[int'(ch_q)*CW +: CW];

  always_comb begin
    pos = 0;
    hit = 1'b0;
    for (int b = 0; b < CW; b++) begin
      if (chunk[b]) begin
        pos = b;
        hit = 1'b1;
      end
    end
  end

  // The lowest chunk always terminates the scan, found or not.
  assign found_o = scan_i && (hit || ch_q == '0);
  assign zero_o  = !hit;
  assign idx_o   = IW'(int'(ch_q) * CW + pos);

  always_comb begin
    ch_d = ch_q;
    if (!scan_i || found_o) ch_d = CIW'(NCH - 1);
    else                    ch_d = ch_q - CIW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) ch_q <= CIW'(NCH - 1);
    else         ch_q <= ch_d;
  end
endmodule
`endif

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving one Montgomery multiplier.
// Define MONT_EXP_SKIP_LZ_EN to skip squaring the exponent's leading zeros.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int E_WIDTH = E_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_WIDTH-1:0] in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N_WIDTH-1:0] in_m,
  input  logic [N_WIDTH-1:0] in_rmodm,
  output logic [N_WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               mult_start,
  output logic [N_WIDTH-1:0] mult_a,
  output logic [N_WIDTH-1:0] mult_b,
  output logic [N_WIDTH-1:0] mult_m,
  input  logic [N_WIDTH-1:0] mult_result,
  input  logic               mult_done
);
  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   x_q, x_d, m_q, m_d, acc_q, acc_d, res_q, res_d;
  logic [E_WIDTH-1:0]   e_q, e_d;
  logic [IW-1:0]        idx_q, idx_d;

`ifdef MONT_EXP_SKIP_LZ_EN
  logic          lz_found, lz_zero;
  logic [IW-1:0] lz_idx;

  mont_lz_scan #(.E_WIDTH(E_WIDTH), .IW(IW)) u_lz_scan (
    .clk     (clk),
    .resetn  (resetn),
    .scan_i  (state_q == S_LOAD),
    .e_i     (e_q),
    .found_o (lz_found),
    .zero_o  (lz_zero),
    .idx_o   (lz_idx)
  );
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    m_d     = m_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = in_x;
        e_d     = in_e;
        m_d     = in_m;
        acc_d   = in_rmodm;
        state_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef MONT_EXP_SKIP_LZ_EN
        if (lz_found) begin
          idx_d   = lz_idx;
          state_d = lz_zero ? S_OUT_REQ : S_SQR_REQ;
        end
`else
        idx_d   = IW'(E_WIDTH - 1);
        state_d = S_SQR_REQ;
`endif
      end
      S_SQR_REQ:  state_d = S_SQR_WAIT;
      S_SQR_WAIT: if (mult_done) begin
        acc_d = mult_result;
        if (e_q[idx_q])        state_d = S_MUL_REQ;
        else if (idx_q == '0)  state_d = S_OUT_REQ;
        else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SQR_REQ;
        end
      end
      S_MUL_REQ:  state_d = S_MUL_WAIT;
      S_MUL_WAIT: if (mult_done) begin
        acc_d = mult_result;
        if (idx_q == '0) state_d = S_OUT_REQ;
        else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SQR_REQ;
        end
      end
      S_OUT_REQ:  state_d = S_OUT_WAIT;
      S_OUT_WAIT: if (mult_done) begin
        res_d   = mult_result;
        state_d = S_DONE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // Operands come straight from registers that only move on mult_done,
  // so they stay stable across each REQ/WAIT pair.
  always_comb begin
    mult_b = '0;
    case (state_q)
      S_SQR_REQ, S_SQR_WAIT: mult_b = acc_q;
      S_MUL_REQ, S_MUL_WAIT: mult_b = x_q;
      S_OUT_REQ, S_OUT_WAIT: mult_b = {{(N_WIDTH-1){1'b0}}, MONT_ONE};
      default:               mult_b = '0;
    endcase
  end

  assign mult_a     = acc_q;
  assign mult_m     = m_q;
  assign mult_start = (state_q == S_SQR_REQ) || (state_q == S_MUL_REQ) || (state_q == S_OUT_REQ);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign result     = res_q;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a random-latency Montgomery multiplier model.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;
  localparam int NW = 8;
  localparam int EW = 8;

  logic          clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [NW-1:0] in_x = '0, in_m = '0, in_rmodm = '0;
  logic [EW-1:0] in_e = '0;
  logic [NW-1:0] result, mult_a, mult_b, mult_m;
  logic          busy, done, mult_start;
  logic [NW-1:0] mult_result = '0;
  logic          mult_done = 1'b0;

  int checks = 0, passes = 0;
  int pulses = 0, sumlat = 0, rem = 0;
  bit outst = 0, spur_en = 0;
  logic [NW-1:0] cap_a, cap_b, cap_m;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.N_WIDTH(NW), .E_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e),
    .in_m(in_m), .in_rmodm(in_rmodm), .result(result), .busy(busy), .done(done),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_m(mult_m),
    .mult_result(mult_result), .mult_done(mult_done)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic longint rinv_of(input longint m);
    for (longint r = 1; r < m; r++) if (((256 * r) % m) == 1) return r;
    return 0;
  endfunction

  function automatic longint mont(input longint a, input longint b, input longint m);
    if (m < 3) return 0;
    return (a * b * rinv_of(m)) % m;
  endfunction

  // Reference: leave Montgomery form, then plain repeated modular multiplication.
  function automatic longint ref_exp(input longint xt, input longint e, input longint m);
    longint x = (xt * rinv_of(m)) % m;
    longint r = 1 % m;
    for (longint k = 0; k < e; k++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int exp_calls(input logic [EW-1:0] e);
`ifdef MONT_EXP_SKIP_LZ_EN
    int msb = -1;
    for (int i = 0; i < EW; i++) if (e[i]) msb = i;
    return (e == '0) ? 1 : msb + 1 + $countones(e) + 1;
`else
    return EW + $countones(e) + 1;
`endif
  endfunction

  // Multiplier model: samples just after the falling edge, drives for the next rising edge.
  initial begin
    forever begin
      @(negedge clk); #1;
      mult_done = 1'b0;
      if (!resetn) begin
        outst = 0;
        rem = 0;
      end else if (mult_start) begin
        chk("start_while_outstanding", longint'(outst), 0);
        outst = 1;
        rem = $urandom_range(3, 20);
        cap_a = mult_a; cap_b = mult_b; cap_m = mult_m;
        pulses++;
        sumlat += 1 + rem;
      end else if (outst) begin
        rem--;
        if (rem == 0) begin
          chk("operands_stable", longint'({mult_a, mult_b, mult_m}), longint'({cap_a, cap_b, cap_m}));
          mult_result = NW'(mont(cap_a, cap_b, cap_m));
          mult_done = 1'b1;
          outst = 0;
        end
      end else if (spur_en) begin
        mult_done = ($urandom_range(0, 3) == 0);
        mult_result = NW'($urandom);
      end
    end
  end

  task automatic wait_done(output int n, output bit got);
    n = 1; got = 0;
    while (!got && n < 3000) begin
      if (done) got = 1;
      else begin @(negedge clk); n++; end
    end
  endtask

  task automatic run_op(input string nm, input logic [NW-1:0] xt, input logic [EW-1:0] e,
                        input logic [NW-1:0] m, input logic [NW-1:0] rm,
                        input logic [NW-1:0] exp_res, input int exp_k);
    int n; bit got;
    @(negedge clk);
    in_x = xt; in_e = e; in_m = m; in_rmodm = rm; start = 1'b1;
    pulses = 0; sumlat = 0;
    @(negedge clk);
    start = 1'b0;
    in_x = NW'($urandom); in_e = EW'($urandom); in_m = NW'($urandom); in_rmodm = NW'($urandom);
    chk({nm, "_busy"}, longint'(busy), 1);
    wait_done(n, got);
    if (!got) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_result"}, longint'(result), longint'(exp_res));
      chk({nm, "_calls"}, pulses, exp_k);
      chk({nm, "_latency"}, n, sumlat + 2);
      @(negedge clk);
      chk({nm, "_done_width"}, longint'({done, busy}), 0);
      chk({nm, "_result_held"}, longint'(result), longint'(exp_res));
    end
  endtask

  typedef struct {
    logic [NW-1:0] x;
    logic [EW-1:0] e;
    logic [NW-1:0] m, rm, res;
  } vec_t;

  initial begin
    vec_t tbl[3];
    int n, ndone, guard, mul_k;
    bit got;
    logic [NW-1:0] rx, rmod;
    logic [EW-1:0] re;

    tbl[0] = '{x: 8'h2D, e: 8'h05, m: 8'hF1, rm: 8'h0F, res: 8'h02};
    tbl[1] = '{x: 8'h2D, e: 8'hFF, m: 8'hF1, rm: 8'h0F, res: 8'h08};
    tbl[2] = '{x: 8'h2D, e: 8'h00, m: 8'hF1, rm: 8'h0F, res: 8'h01};

    repeat (3) @(negedge clk);
    chk("reset_outputs", longint'({result, busy, done, mult_start, mult_a, mult_b, mult_m}), 0);
    resetn = 1'b1;

    for (int i = 0; i < 3; i++)
      run_op($sformatf("vec%0d", i), tbl[i].x, tbl[i].e, tbl[i].m, tbl[i].rm, tbl[i].res,
             exp_calls(tbl[i].e));

    // Restart attempt mid-run, then a start landing in the DONE cycle.
    @(negedge clk);
    in_x = 8'h2D; in_e = 8'h05; in_m = 8'hF1; in_rmodm = 8'h0F; start = 1'b1;
    pulses = 0; sumlat = 0;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (pulses < 1 && guard < 100) begin @(negedge clk); guard++; end
    chk("restart_reached_sqr_wait", longint'(pulses >= 1), 1);
    in_x = 8'h11; in_e = 8'hFF; in_m = 8'hC5; in_rmodm = 8'h3B; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(n, got);
    chk("restart_done_seen", longint'(got), 1);
    chk("restart_result", longint'(result), 2);
    chk("restart_calls", pulses, exp_calls(8'h05));
    start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); start = 1'b0;
      if (done) ndone++;
      if (c == 1) chk("start_in_done_ignored", longint'(busy), 0);
    end
    chk("restart_single_done", ndone, 0);

    // Reset pulse while waiting on the first multiply of e=0x05.
`ifdef MONT_EXP_SKIP_LZ_EN
    mul_k = 2;
`else
    mul_k = 7;
`endif
    @(negedge clk);
    in_x = 8'h2D; in_e = 8'h05; in_m = 8'hF1; in_rmodm = 8'h0F; start = 1'b1;
    pulses = 0;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (pulses < mul_k && guard < 500) begin @(negedge clk); guard++; end
    chk("reset_reached_mul_wait", longint'(mult_b == 8'h2D && busy), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", longint'({busy, done, mult_start, result, mult_a, mult_b, mult_m}), 0);
    resetn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (done || busy) ndone++; end
    chk("midrun_reset_quiet", ndone, 0);
    run_op("after_reset", 8'h2D, 8'h05, 8'hF1, 8'h0F, 8'h02, exp_calls(8'h05));

    // Random operands, odd moduli, spurious mult_done outside WAIT states.
    spur_en = 1;
    for (int i = 0; i < 16; i++) begin
      rmod = NW'($urandom_range(1, 127) * 2 + 1);
      rx   = NW'($urandom % rmod);
      re   = EW'($urandom);
      run_op($sformatf("rnd%0d", i), rx, re, rmod, NW'(256 % rmod),
             NW'(ref_exp(rx, re, rmod)), exp_calls(re));
    end
    spur_en = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
